// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch with one-cycle memory latency, a one-word skid for decode stalls,
// and redirect squashing of stale fetches.
module if_fetch_stage #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              im_read_o,
  output logic [ADDR_W-1:0] im_addr_o,
  input  logic [DATA_W-1:0] im_data_i,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_pc_o
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_inst;
  logic [ADDR_W-1:0] r_skid_pc;
  assign im_read_o = !rst && (redirect_i || !stall_i);
  assign im_addr_o = redirect_i ? redirect_pc_i : r_pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_req_pc     <= '0;
      r_skid_valid <= 1'b0;
      r_skid_inst  <= '0;
      r_skid_pc    <= '0;
      id_valid_o   <= 1'b0;
      id_inst_o    <= '0;
      id_pc_o      <= '0;
    end else if (redirect_i) begin
      r_pc         <= redirect_pc_i + 1'b1;
      r_req_valid  <= 1'b1;
      r_req_pc     <= redirect_pc_i;
      r_skid_valid <= 1'b0;
      id_valid_o   <= 1'b0;
      id_inst_o    <= '0;
      id_pc_o      <= '0;
    end else if (stall_i) begin
      // No read issues while stalled, so the skid can only ever be filled once.
      r_req_valid <= 1'b0;
      if (r_req_valid) begin
        r_skid_valid <= 1'b1;
        r_skid_inst  <= im_data_i;
        r_skid_pc    <= r_req_pc;
      end
    end else begin
      id_valid_o   <= r_skid_valid || r_req_valid;
      id_inst_o    <= r_skid_valid ? r_skid_inst : r_req_valid ? im_data_i : '0;
      id_pc_o      <= r_skid_valid ? r_skid_pc : r_req_valid ? r_req_pc : '0;
      r_skid_valid <= 1'b0;
      r_pc         <= r_pc + 1'b1;
      r_req_valid  <= 1'b1;
      r_req_pc     <= r_pc;
    end
  end
  a_one_word_outstanding: assert property (@(posedge clk) disable iff (rst) !(r_skid_valid && r_req_valid));
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized stall/redirect stimulus on a 16-bit and a 4-bit instance, scored against
// a transaction-level model of the fetch stream.
module tb_if_fetch_stage;
  typedef struct packed {
    logic        v;
    logic [31:0] inst;
    logic [15:0] pc;
  } ent_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [15:0] tgt = '0;
  logic [31:0] md0 = '0;
  logic [31:0] md1 = '0;
  logic        rd0, vld0, rd1, vld1;
  logic [15:0] addr0, pc0;
  logic [3:0]  addr1, pc1;
  logic [31:0] inst0, inst1;
  int          checks = 0;
  int          failures = 0;
  ent_t        q0[$];
  ent_t        q1[$];
  int          m_pc[2];
  int          pp[2];
  bit          pv[2];
  ent_t        hold[2];
  always #5 clk = ~clk;
  if_fetch_stage #(.ADDR_W(16), .DATA_W(32)) u16 (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(tgt),
    .im_read_o(rd0), .im_addr_o(addr0), .im_data_i(md0),
    .id_valid_o(vld0), .id_inst_o(inst0), .id_pc_o(pc0)
  );
  if_fetch_stage #(.ADDR_W(4), .DATA_W(32)) u4 (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(tgt[3:0]),
    .im_read_o(rd1), .im_addr_o(addr1), .im_data_i(md1),
    .id_valid_o(vld1), .id_inst_o(inst1), .id_pc_o(pc1)
  );
  function automatic logic [31:0] mem(input int a);
    return 32'h1000_0000 + 32'(a);
  endfunction
  function automatic int msk(input int k);
    return k == 0 ? 32'hffff : 15;
  endfunction
  always_ff @(posedge clk) begin
    md0 <= rd0 ? mem(int'(addr0)) : '0;
    md1 <= rd1 ? mem(int'(addr1)) : '0;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Model: the fetch stream holds at most one fetched word awaiting delivery to decode.
  initial forever begin
    ent_t e;
    int   t;
    @(posedge clk or posedge rst);
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        m_pc[k] = 0;
        pp[k]   = 0;
        pv[k]   = 1'b0;
        hold[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = hold[k];
        t = int'(tgt) & msk(k);
        if (redir) begin
          e       = '0;
          pv[k]   = 1'b1;
          pp[k]   = t;
          m_pc[k] = (t + 1) & msk(k);
        end else if (!stall) begin
          e       = pv[k] ? '{v: 1'b1, inst: mem(pp[k]), pc: 16'(pp[k])} : '0;
          pv[k]   = 1'b1;
          pp[k]   = m_pc[k];
          m_pc[k] = (m_pc[k] + 1) & msk(k);
        end
        hold[k] = e;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
      end
    end
  end
  initial forever begin
    ent_t e;
    @(negedge clk);
    if (rst) begin
      chk("rst_id0", {vld0, inst0, pc0}, '0);
      chk("rst_id1", {vld1, inst1, pc1}, '0);
      chk("rst_rd0", 64'(rd0), '0);
      chk("rst_rd1", 64'(rd1), '0);
    end else begin
      chk("rd0", 64'(rd0), 64'(redir || !stall));
      chk("rd1", 64'(rd1), 64'(redir || !stall));
      chk("addr0", 64'(addr0), redir ? 64'(tgt) : 64'(m_pc[0]));
      chk("addr1", 64'(addr1), redir ? 64'(tgt[3:0]) : 64'(m_pc[1]));
      if (q0.size() == 0 || q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: got q0=%0d q1=%0d entries expected at least 1", q0.size(), q1.size());
      end else begin
        e = q0.pop_front();
        chk("id0", {vld0, inst0, pc0}, e);
        e = q1.pop_front();
        chk("id1", {vld1, inst1, 12'h0, pc1}, e);
      end
    end
  end
  task automatic cyc(input bit s, input bit r, input logic [15:0] t);
    @(posedge clk);
    #1;
    stall = s;
    redir = r;
    tgt   = t;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("first_rd", 64'(rd0), 64'(1));
    chk("first_addr", 64'(addr0), 64'(0));
    repeat (8) cyc(0, 0, 0);
    repeat (3) cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    cyc(0, 1, 16'h0040);
    repeat (5) cyc(0, 0, 0);
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 16'h0080);
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    cyc(0, 1, 16'hfffe);
    repeat (5) cyc(0, 0, 0);
    cyc(0, 1, 16'h000f);
    repeat (5) cyc(0, 0, 0);
    repeat (2) cyc(1, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_id0", {vld0, inst0, pc0}, '0);
    chk("async_id1", {vld1, inst1, pc1}, '0);
    chk("async_rd", {63'h0, rd0 | rd1}, '0);
    @(negedge clk);
    #1;
    stall = 1'b0;
    rst   = 1'b0;
    repeat (6) cyc(0, 0, 0);
    repeat (3000) begin
      logic [15:0] t;
      t = ($urandom_range(0, 3) == 0) ? 16'hfff0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, t);
    end
    repeat (3) cyc(0, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
